// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
//   state_e   : FSM encoding (IDLE=0, SHIFT=1)
//   cnt_width : bit-counter width for a given word width
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter width needed to count 0..w-1; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_shift_reg.sv
// Word shift register for the serializer.
// It holds the bits that still follow the bit currently on ser_out, so a
// load stores d already advanced by one position. q_bit is the next bit out.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture d (priority over shift)
//   shift      : advance one bit toward the output end
//   d          : parallel word
//   q_bit      : next bit to be emitted
module piso_serializer_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Next register contents; load wins over shift.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = MSB_FIRST ? {d[WIDTH-2:0], 1'b0} : {1'b0, d[WIDTH-1:1]};
    end else if (shift) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign q_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the serial delay-line input.
// Accepts a WIDTH-bit word on valid/ready and emits it one bit per clk,
// back-to-back words without an idle gap.
//   clk, reset : clock, asynchronous active-high reset
//   din        : parallel word, sampled on din_valid && din_ready
//   din_valid  : din is valid
//   din_ready  : combinational; ready in IDLE or on the last bit of a word
//   ser_out    : registered serial data (IDLE_LEVEL when not shifting)
//   ser_frame  : registered; high while ser_out carries a data bit
//   word_done  : registered; high while the last bit of a word is on ser_out
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             word_done
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            ser_out_q, ser_out_d;
  logic            frame_q, frame_d;
  logic            done_q, done_d;
  logic            load, shift, next_bit, first_bit, last_bit, transfer;

  piso_serializer_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     (din),
    .q_bit (next_bit)
  );

  assign last_bit  = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_LAST);
  assign din_ready = (state_q == ST_IDLE) || last_bit;
  assign transfer  = din_valid && din_ready;
  assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ser_out_d = IDLE_LEVEL;
    frame_d   = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    if (transfer) begin
      // Accepted word: its first bit goes out in the very next cycle.
      load      = 1'b1;
      state_d   = ST_SHIFT;
      bit_cnt_d = '0;
      ser_out_d = first_bit;
      frame_d   = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (last_bit) begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end else begin
        shift     = 1'b1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        ser_out_d = next_bit;
        frame_d   = 1'b1;
        done_d    = (bit_cnt_q + CW'(1)) == CNT_LAST;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      ser_out_q <= IDLE_LEVEL;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ser_out_q <= ser_out_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_frame = frame_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: three serializer configurations (8-bit MSB-first,
// 8-bit LSB-first, 2-bit MSB-first) sharing clock and reset.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // 8-bit MSB-first
  logic [7:0] a_din = '0;
  logic a_valid = 1'b0, a_ready, a_ser, a_frame, a_done;
  // 8-bit LSB-first
  logic [7:0] b_din = '0;
  logic b_valid = 1'b0, b_ready, b_ser, b_frame, b_done;
  // 2-bit MSB-first
  logic [1:0] c_din = '0;
  logic c_valid = 1'b0, c_ready, c_ser, c_frame, c_done;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .reset(reset), .din(a_din), .din_valid(a_valid),
    .din_ready(a_ready), .ser_out(a_ser), .ser_frame(a_frame), .word_done(a_done));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
    .clk(clk), .reset(reset), .din(b_din), .din_valid(b_valid),
    .din_ready(b_ready), .ser_out(b_ser), .ser_frame(b_frame), .word_done(b_done));

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
    .clk(clk), .reset(reset), .din(c_din), .din_valid(c_valid),
    .din_ready(c_ready), .ser_out(c_ser), .ser_frame(c_frame), .word_done(c_done));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one bit cycle of DUT a: data, frame, done, ready.
  task automatic chk_a(input string tag, input logic exp_bit, input logic exp_done,
                       input logic exp_ready);
    check({tag, "_ser"},   32'(a_ser),   32'(exp_bit));
    check({tag, "_frame"}, 32'(a_frame), 32'd1);
    check({tag, "_done"},  32'(a_done),  32'(exp_done));
    check({tag, "_ready"}, 32'(a_ready), 32'(exp_ready));
  endtask

  logic [7:0] pat;

  initial begin
    // ---- reset values ----
    #2;
    check("rst_a_ser", 32'(a_ser), 32'd0);
    check("rst_a_frame", 32'(a_frame), 32'd0);
    check("rst_a_done", 32'(a_done), 32'd0);
    check("rst_b_frame", 32'(b_frame), 32'd0);
    check("rst_c_frame", 32'(c_frame), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("idle_a_ready", 32'(a_ready), 32'd1);
    check("idle_c_ready", 32'(c_ready), 32'd1);

    // ---- 1: A5 MSB-first, valid pulsed one cycle ----
    a_din = 8'hA5; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_din = 8'h00;
    pat = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t1_b%0d", i), pat[7-i], i == 7, i == 7);
      tick();
    end
    check("t1_idle_ser", 32'(a_ser), 32'd0);
    check("t1_idle_frame", 32'(a_frame), 32'd0);
    check("t1_idle_done", 32'(a_done), 32'd0);

    // ---- 2: 01 LSB-first ----
    b_din = 8'h01; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_b%0d_ser", i), 32'(b_ser), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_b%0d_frame", i), 32'(b_frame), 32'd1);
      check($sformatf("t2_b%0d_done", i), 32'(b_done), (i == 7) ? 32'd1 : 32'd0);
      tick();
    end
    check("t2_idle_ser", 32'(b_ser), 32'd0);
    check("t2_idle_frame", 32'(b_frame), 32'd0);

    // ---- 3: back-to-back FF then 00 with valid held ----
    a_din = 8'hFF; a_valid = 1'b1;
    check("t3_ready_idle", 32'(a_ready), 32'd1);
    tick();
    a_din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t3_w0_b%0d", i), 1'b1, i == 7, i == 7);
      tick();
    end
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t3_w1_b%0d", i), 1'b0, i == 7, i == 7);
      tick();
    end
    check("t3_end_frame", 32'(a_frame), 32'd0);
    check("t3_end_ready", 32'(a_ready), 32'd1);

    // ---- 4: valid raised mid-word, accepted on last bit ----
    a_din = 8'h3C; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    pat = 8'b0011_1100;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        a_din = 8'h81; a_valid = 1'b1;
      end
      chk_a($sformatf("t4_w0_b%0d", i), pat[7-i], i == 7, i == 7);
      tick();
    end
    a_valid = 1'b0; a_din = 8'h00;
    pat = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t4_w1_b%0d", i), pat[7-i], i == 7, i == 7);
      tick();
    end
    check("t4_end_frame", 32'(a_frame), 32'd0);

    // ---- 5: async reset mid-word of C3 ----
    a_din = 8'hC3; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    pat = 8'b1100_0011;
    for (int i = 0; i < 5; i++) begin
      chk_a($sformatf("t5_b%0d", i), pat[7-i], 1'b0, 1'b0);
      if (i < 4) tick();
    end
    #2 reset = 1'b1;
    #1;
    check("t5_async_ser", 32'(a_ser), 32'd0);
    check("t5_async_frame", 32'(a_frame), 32'd0);
    check("t5_async_done", 32'(a_done), 32'd0);
    a_din = 8'hA5; a_valid = 1'b1;
    tick();
    check("t5_rstwin_frame", 32'(a_frame), 32'd0);
    a_valid = 1'b0;
    reset = 1'b0;
    check("t5_rel_ready", 32'(a_ready), 32'd1);
    tick();
    check("t5_rel_frame", 32'(a_frame), 32'd0);
    check("t5_rel_ser", 32'(a_ser), 32'd0);
    a_din = 8'h5A; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    pat = 8'b0101_1010;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("t5_new_b%0d", i), pat[7-i], i == 7, i == 7);
      tick();
    end
    check("t5_end_frame", 32'(a_frame), 32'd0);

    // ---- 6: WIDTH=2, 2'b10 three times back-to-back ----
    c_din = 2'b10; c_valid = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t6_c%0d_ser", i), 32'(c_ser), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t6_c%0d_frame", i), 32'(c_frame), 32'd1);
      check($sformatf("t6_c%0d_done", i), 32'(c_done), (i % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("t6_c%0d_ready", i), 32'(c_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      if (i == 3) c_valid = 1'b0;
    end
    check("t6_end_frame", 32'(c_frame), 32'd0);
    check("t6_end_ser", 32'(c_ser), 32'd0);
    check("t6_end_done", 32'(c_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
